// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface fetch_stage_if;
    logic [15:0] addr;
    logic        rd;
    logic [15:0] data;
    logic        valid;

    modport master (output addr, output rd, input data, input valid);
    modport slave  (input addr, input rd, output data, output valid);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request, IF/ID register, HLT detection.
// Optional bubble counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [15:0]          branch_target,
    fetch_stage_if.master        imem,
    output logic [15:0]          if_id_pc,
    output logic [15:0]          if_id_pc_plus2,
    output logic [15:0]          if_id_instr,
    output logic                 if_id_valid,
    output logic                 halted,
    output logic [15:0]          fetch_bubbles
);

    typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, HALT = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] if_id_pc_nxt, if_id_pc_plus2_nxt, if_id_instr_nxt;
    logic        if_id_valid_nxt, halted_nxt;
    logic        bubble_load;

    assign imem.addr = pc;
    assign imem.rd   = (state != HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_id_pc       <= 16'h0000;
            if_id_pc_plus2 <= 16'h0000;
            if_id_instr    <= NOP_INSTR;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            if_id_pc       <= if_id_pc_nxt;
            if_id_pc_plus2 <= if_id_pc_plus2_nxt;
            if_id_instr    <= if_id_instr_nxt;
            if_id_valid    <= if_id_valid_nxt;
            halted         <= halted_nxt;
        end
    end

    // Priority: redirect, then stall, then memory response.
    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc;
        if_id_pc_nxt       = if_id_pc;
        if_id_pc_plus2_nxt = if_id_pc_plus2;
        if_id_instr_nxt    = if_id_instr;
        if_id_valid_nxt    = if_id_valid;
        halted_nxt         = halted;
        bubble_load        = 1'b0;

        if (branch_taken) begin
            pc_nxt          = {branch_target[15:1], 1'b0};
            if_id_instr_nxt = NOP_INSTR;
            if_id_valid_nxt = 1'b0;
            state_nxt       = RUN;
            halted_nxt      = 1'b0;
            bubble_load     = 1'b1;
        end else if (stall) begin
            // Hold everything; any response this cycle is dropped and re-read.
        end else if (state == HALT) begin
            if_id_instr_nxt = NOP_INSTR;
            if_id_valid_nxt = 1'b0;
            bubble_load     = 1'b1;
        end else if (imem.valid) begin
            if_id_pc_nxt       = pc;
            if_id_pc_plus2_nxt = pc + 16'd2;
            if_id_instr_nxt    = imem.data;
            if_id_valid_nxt    = 1'b1;
            if (imem.data[15:12] == HALT_OPCODE) begin
                state_nxt  = HALT;
                halted_nxt = 1'b1;
            end else begin
                pc_nxt    = pc + 16'd2;
                state_nxt = RUN;
            end
        end else begin
            if_id_instr_nxt = NOP_INSTR;
            if_id_valid_nxt = 1'b0;
            state_nxt       = WAIT;
            bubble_load     = 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= 16'h0000;
        end else if (bubble_load && !stall && !halted && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign fetch_bubbles = bubble_cnt;
`else
    assign fetch_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] if_id_pc, if_id_pc_plus2, if_id_instr, fetch_bubbles;
    logic        if_id_valid, halted;
    int          n_cmp = 0;
    int          n_bad = 0;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem           (imem.master),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_bubbles  (fetch_bubbles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [15:0] tgt);
        branch_taken  = 1'b1;
        branch_target = tgt;
        step();
        branch_taken  = 1'b0;
    endtask

    initial begin
        imem.valid = 1'b0;
        imem.data  = 16'h0000;
        #2;
        chk("rst_addr", imem.addr, 16'h0000);
        chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_pc", if_id_pc, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_rd", {15'd0, imem.rd}, 16'd1);
        chk("rst_bubbles", fetch_bubbles, 16'h0000);
        step();
        rst = 1'b0;

        // Back-to-back responses
        imem.valid = 1'b1;
        imem.data  = 16'h1234;
        step();
        chk("t1_pc0", if_id_pc, 16'h0000);
        chk("t1_v0", {15'd0, if_id_valid}, 16'd1);
        chk("t1_i0", if_id_instr, 16'h1234);
        chk("t1_a0", imem.addr, 16'h0002);
        imem.data = 16'h1236;
        step();
        chk("t1_pc1", if_id_pc, 16'h0002);
        chk("t1_p2_1", if_id_pc_plus2, 16'h0004);
        chk("t1_a1", imem.addr, 16'h0004);
        imem.data = 16'h1238;
        step();
        chk("t1_pc2", if_id_pc, 16'h0004);
        chk("t1_a2", imem.addr, 16'h0006);

        // Memory wait states at 0x0010
        imem.valid = 1'b0;
        redirect(16'h0010);
        chk("t2_addr_br", imem.addr, 16'h0010);
        chk("t2_flush", {15'd0, if_id_valid}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_wait_addr", imem.addr, 16'h0010);
            chk("t2_wait_v", {15'd0, if_id_valid}, 16'd0);
            chk("t2_wait_i", if_id_instr, 16'h0000);
        end
        imem.valid = 1'b1;
        imem.data  = 16'h2222;
        step();
        chk("t2_pc", if_id_pc, 16'h0010);
        chk("t2_instr", if_id_instr, 16'h2222);
        chk("t2_v", {15'd0, if_id_valid}, 16'd1);
        chk("t2_addr", imem.addr, 16'h0012);
`ifdef FETCH_PERF_CNT_EN
        chk("t2_bubbles", fetch_bubbles, 16'd4);
`else
        chk("t2_bubbles", fetch_bubbles, 16'd0);
`endif

        // Stall with responses present
        stall     = 1'b1;
        imem.data = 16'h3333;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_addr", imem.addr, 16'h0012);
            chk("t4_pc", if_id_pc, 16'h0010);
            chk("t4_instr", if_id_instr, 16'h2222);
            chk("t4_rd", {15'd0, imem.rd}, 16'd1);
        end
        stall = 1'b0;
        step();
        chk("t4_rel_pc", if_id_pc, 16'h0012);
        chk("t4_rel_instr", if_id_instr, 16'h3333);
        chk("t4_rel_addr", imem.addr, 16'h0014);
`ifdef FETCH_PERF_CNT_EN
        chk("t4_bubbles", fetch_bubbles, 16'd4);
`endif

        // Branch overrides stall; bit0 of target dropped
        stall = 1'b1;
        redirect(16'h0041);
        stall = 1'b0;
        chk("t3_addr", imem.addr, 16'h0040);
        chk("t3_v", {15'd0, if_id_valid}, 16'd0);
        chk("t3_instr", if_id_instr, 16'h0000);

        // PC wrap
        imem.valid = 1'b0;
        redirect(16'hFFFE);
        imem.valid = 1'b1;
        imem.data  = 16'h4444;
        step();
        chk("t5_pc", if_id_pc, 16'hFFFE);
        chk("t5_p2", if_id_pc_plus2, 16'h0000);
        chk("t5_addr", imem.addr, 16'h0000);

        // HLT capture then release by branch
        imem.valid = 1'b0;
        redirect(16'h0008);
        imem.valid = 1'b1;
        imem.data  = 16'hF000;
        step();
        chk("t6_halted", {15'd0, halted}, 16'd1);
        chk("t6_rd", {15'd0, imem.rd}, 16'd0);
        chk("t6_addr", imem.addr, 16'h0008);
        chk("t6_instr", if_id_instr, 16'hF000);
        chk("t6_v", {15'd0, if_id_valid}, 16'd1);
        imem.data = 16'h5555;
        step();
        chk("t6_hold_v", {15'd0, if_id_valid}, 16'd0);
        chk("t6_hold_addr", imem.addr, 16'h0008);
        chk("t6_hold_halted", {15'd0, halted}, 16'd1);
        imem.valid = 1'b0;
        redirect(16'h0020);
        chk("t6_unhalt", {15'd0, halted}, 16'd0);
        chk("t6_rd_again", {15'd0, imem.rd}, 16'd1);
        chk("t6_addr_br", imem.addr, 16'h0020);
        imem.valid = 1'b1;
        step();
        chk("t6_pc", if_id_pc, 16'h0020);
        chk("t6_instr2", if_id_instr, 16'h5555);

        // Reset while a fetch is outstanding
        imem.valid = 1'b0;
        step();
        chk("rw_addr_pre", imem.addr, 16'h0022);
        rst = 1'b1;
        #2;
        chk("rw_addr", imem.addr, 16'h0000);
        chk("rw_valid", {15'd0, if_id_valid}, 16'd0);
        imem.valid = 1'b1;
        imem.data  = 16'h6666;
        step();
        rst = 1'b0;
        step();
        chk("rw_pc", if_id_pc, 16'h0000);
        chk("rw_instr", if_id_instr, 16'h6666);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
